// File: rtl/hci_package.sv
// rtl/hci_package.sv - shared types and default widths for the HCI bank arbiter
package hci_package;

    localparam int DEFAULT_AW = 32;
    localparam int DEFAULT_DW = 32;
    localparam int DEFAULT_BW = 8;
    localparam int DEFAULT_UW = 1;
    localparam int DEFAULT_SW = 8;

    typedef struct packed {
        logic                  invert_prio;
        logic [DEFAULT_SW-1:0] max_stall;
    } hci_bank_arb_ctrl_t;

    typedef enum logic {
        NORMAL = 1'b0,
        BOOST  = 1'b1
    } hci_bank_arb_state_e;

endpackage

// File: rtl/hci_arb_stall_counter.sv
// rtl/hci_arb_stall_counter.sv - saturating lost-arbitration counter with boost threshold detect
module hci_arb_stall_counter
    import hci_package::*;
#(
    parameter int SW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic [SW-1:0] max_stall_i,
    input  logic          lp_req_i,
    input  logic          lp_gnt_i,
    input  logic          hp_gnt_i,
    output logic [SW-1:0] cnt_o,
    output logic          hit_o
);

    logic [SW-1:0] cnt_q;
    logic          enable;
    logic          incr;

    assign enable = (max_stall_i != '0);
    assign incr   = enable & lp_req_i & hp_gnt_i;
    // Threshold is reached by the loss happening now, so the boost lands on the very next cycle.
    assign hit_o  = incr & (cnt_q == max_stall_i - SW'(1));
    assign cnt_o  = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i || !enable || !lp_req_i || lp_gnt_i || hit_o) begin
            cnt_q <= '0;
        end else if (incr && (cnt_q != max_stall_i)) begin
            cnt_q <= cnt_q + SW'(1);
        end
    end

endmodule

// File: rtl/hci_bank_starvation_arbiter.sv
// rtl/hci_bank_starvation_arbiter.sv - fixed-priority two-way TCDM bank arbiter with LP starvation boost
module hci_bank_starvation_arbiter
    import hci_package::*;
#(
    parameter int AW = hci_package::DEFAULT_AW,
    parameter int DW = hci_package::DEFAULT_DW,
    parameter int BW = hci_package::DEFAULT_BW,
    parameter int UW = hci_package::DEFAULT_UW,
    parameter int IW = 8,
    parameter int SW = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  hci_bank_arb_ctrl_t ctrl_i,
    input  logic               in0_req_i,
    input  logic [AW-1:0]      in0_add_i,
    input  logic               in0_wen_i,
    input  logic [DW-1:0]      in0_data_i,
    input  logic [DW/BW-1:0]   in0_be_i,
    input  logic [UW-1:0]      in0_user_i,
    input  logic [IW-1:0]      in0_id_i,
    output logic               in0_gnt_o,
    output logic               in0_r_valid_o,
    output logic [DW-1:0]      in0_r_data_o,
    output logic [UW-1:0]      in0_r_user_o,
    output logic [IW-1:0]      in0_r_id_o,
    input  logic               in1_req_i,
    input  logic [AW-1:0]      in1_add_i,
    input  logic               in1_wen_i,
    input  logic [DW-1:0]      in1_data_i,
    input  logic [DW/BW-1:0]   in1_be_i,
    input  logic [UW-1:0]      in1_user_i,
    input  logic [IW-1:0]      in1_id_i,
    output logic               in1_gnt_o,
    output logic               in1_r_valid_o,
    output logic [DW-1:0]      in1_r_data_o,
    output logic [UW-1:0]      in1_r_user_o,
    output logic [IW-1:0]      in1_r_id_o,
    output logic               out_req_o,
    output logic [AW-1:0]      out_add_o,
    output logic               out_wen_o,
    output logic [DW-1:0]      out_data_o,
    output logic [DW/BW-1:0]   out_be_o,
    output logic [UW-1:0]      out_user_o,
    output logic [IW-1:0]      out_id_o,
    input  logic               out_gnt_i,
    input  logic [DW-1:0]      out_r_data_i,
    input  logic [UW-1:0]      out_r_user_i
);

    hci_bank_arb_state_e state_q;
    logic                invert_q;
    logic                r_valid0_q, r_valid1_q;
    logic [IW-1:0]       r_id_q;
    logic [SW-1:0]       max_stall;
    logic [SW-1:0]       cnt;
    logic                hit;
    logic                prio_change;
    logic                prio_side, prio_req, winner;
    logic                lp_req, lp_gnt, hp_gnt, handshake;

    assign max_stall   = SW'(ctrl_i.max_stall);
    assign prio_change = (ctrl_i.invert_prio != invert_q);

    // Sides are resolved from the registered invert bit so a toggle takes effect one cycle later.
    assign prio_side = invert_q ^ (state_q == BOOST);
    assign prio_req  = prio_side ? in1_req_i : in0_req_i;
    assign winner    = prio_req ? prio_side : ~prio_side;

    assign in0_gnt_o = ~winner & in0_req_i & out_gnt_i;
    assign in1_gnt_o =  winner & in1_req_i & out_gnt_i;
    assign handshake = in0_gnt_o | in1_gnt_o;

    assign lp_req = invert_q ? in0_req_i : in1_req_i;
    assign lp_gnt = invert_q ? in0_gnt_o : in1_gnt_o;
    assign hp_gnt = invert_q ? in1_gnt_o : in0_gnt_o;

    assign out_req_o  = in0_req_i | in1_req_i;
    assign out_add_o  = winner ? in1_add_i  : in0_add_i;
    assign out_wen_o  = winner ? in1_wen_i  : in0_wen_i;
    assign out_data_o = winner ? in1_data_i : in0_data_i;
    assign out_be_o   = winner ? in1_be_i   : in0_be_i;
    assign out_user_o = winner ? in1_user_i : in0_user_i;
    assign out_id_o   = winner ? in1_id_i   : in0_id_i;

    assign in0_r_valid_o = r_valid0_q;
    assign in1_r_valid_o = r_valid1_q;
    assign in0_r_id_o    = r_id_q;
    assign in1_r_id_o    = r_id_q;
    assign in0_r_data_o  = out_r_data_i;
    assign in1_r_data_o  = out_r_data_i;
    assign in0_r_user_o  = out_r_user_i;
    assign in1_r_user_o  = out_r_user_i;

    hci_arb_stall_counter #(
        .SW (SW)
    ) u_stall_counter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clear_i | prio_change),
        .max_stall_i (max_stall),
        .lp_req_i    (lp_req),
        .lp_gnt_i    (lp_gnt),
        .hp_gnt_i    (hp_gnt),
        .cnt_o       (cnt),
        .hit_o       (hit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= NORMAL;
            invert_q   <= 1'b0;
            r_valid0_q <= 1'b0;
            r_valid1_q <= 1'b0;
            r_id_q     <= '0;
        end else begin
            invert_q <= ctrl_i.invert_prio;
            if (clear_i || prio_change) begin
                state_q <= NORMAL;
            end else begin
                case (state_q)
                    NORMAL:  if (hit) state_q <= BOOST;
                    BOOST:   if (lp_gnt || !lp_req) state_q <= NORMAL;
                    default: state_q <= NORMAL;
                endcase
            end
            // Response tracking ignores clear/priority changes so in-flight data reaches its owner.
            r_valid0_q <= in0_gnt_o;
            r_valid1_q <= in1_gnt_o;
            if (handshake) begin
                r_id_q <= out_id_o;
            end
        end
    end

endmodule
